serial_adder: RTL and testbench

- Multi-cycle, bit-serial WIDTH-bit adder built around a single half-adder pair plus a carry flip-flop (full-adder cell), processing one bit per clock, LSB first.
- Sits directly downstream of the combinational half-adder stage: it consumes that stage's sum/carry bits and turns them into a registered word-level add with a start/done handshake.
- Used where area matters more than latency.

---
 rtl/serial_adder.sv | 120 ++++++++++++
 tb/tb_serial_adder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// A start in IDLE captures the operands; done pulses one cycle after the last bit.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] w_sum_next;
    logic             r_c;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             w_s;
    logic             w_c_next;
    logic             w_load;
    logic             w_step;
    logic             w_last;

    assign w_s      = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
    assign w_c_next = (r_a_sh[0] & r_b_sh[0]) | (r_c & (r_a_sh[0] ^ r_b_sh[0]));
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // The new bit enters at the MSB, so after WIDTH shifts bit 0 lands at sum[0].
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign w_sum_next = w_s;
        end else begin : g_sum_wn
            assign w_sum_next = {w_s, r_sum[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = ADD;
                end
            end
            ADD: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_c     <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_c    <= cin;
            r_cnt  <= '0;
        end else if (w_step) begin
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh >> 1;
            r_sum  <= w_sum_next;
            r_c    <= w_c_next;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_carry <= w_c_next;
            end
        end
    end

    assign sum   = r_sum;
    assign carry = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=4): vector table, multi-cycle corner cases
// and an exhaustive sweep against a + b + cin.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [3:0] sum;
    logic       carry;

    int total = 0;
    int bad   = 0;

    serial_adder #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .carry(carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] s;
        logic       c;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
    task automatic run_op(input logic [3:0] oa, input logic [3:0] ob, input logic oc,
                          output logic [4:0] res, output int lat, output int nbusy);
        start = 1'b1;
        a     = oa;
        b     = ob;
        cin   = oc;
        res   = '0;
        lat   = -1;
        nbusy = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                a     = ~oa;
                b     = ~ob;
                cin   = ~oc;
            end
            if (done) begin
                lat = i;
                res = {carry, sum};
                break;
            end
            if (busy) nbusy++;
        end
    endtask

    initial begin
        vec_t       vecs[10];
        logic [4:0] res;
        int         lat;
        int         nbusy;
        int         ndone;
        int         last_done;
        logic [4:0] exp5;

        vecs[0] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0};
        vecs[1] = '{4'd5,  4'd3,  1'b0, 4'd8,  1'b0};
        vecs[2] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1};
        vecs[3] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
        vecs[4] = '{4'd9,  4'd6,  1'b1, 4'd0,  1'b1};
        vecs[5] = '{4'd7,  4'd8,  1'b0, 4'd15, 1'b0};
        vecs[6] = '{4'd10, 4'd5,  1'b1, 4'd0,  1'b1};
        vecs[7] = '{4'd12, 4'd10, 1'b0, 4'd6,  1'b1};
        vecs[8] = '{4'd1,  4'd1,  1'b1, 4'd3,  1'b0};
        vecs[9] = '{4'd0,  4'd15, 1'b1, 4'd0,  1'b1};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset busy",  busy,  0);
        check("reset done",  done,  0);
        check("reset sum",   sum,   0);
        check("reset carry", carry, 0);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, res, lat, nbusy);
            check($sformatf("vec%0d latency", i), lat, 5);
            check($sformatf("vec%0d busy cycles", i), nbusy, 4);
            check($sformatf("vec%0d sum", i), res[3:0], vecs[i].s);
            check($sformatf("vec%0d carry", i), res[4], vecs[i].c);
            @(negedge clk);
            check($sformatf("vec%0d done width", i), done, 0);
            check($sformatf("vec%0d hold", i), {carry, sum}, {vecs[i].c, vecs[i].s});
        end

        // start held high with new operands while busy must be ignored
        start = 1'b1;
        a     = 4'd6;
        b     = 4'd7;
        cin   = 1'b0;
        lat   = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                a = 4'd1;
                b = 4'd1;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        check("busy-start latency", lat, 5);
        check("busy-start result", {carry, sum}, 5'd13);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("busy-start no second op", ndone, 0);

        // reset in the middle of an add aborts it without a done pulse
        start = 1'b1;
        a     = 4'd9;
        b     = 4'd9;
        cin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort busy",  busy,  0);
        check("abort done",  done,  0);
        check("abort sum",   sum,   0);
        check("abort carry", carry, 0);
        rst   = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort no done", ndone, 0);
        run_op(4'd2, 4'd2, 1'b0, res, lat, nbusy);
        check("after abort latency", lat, 5);
        check("after abort result", res, 5'd4);
        @(negedge clk);

        // start held continuously: one result every WIDTH+2 cycles
        start     = 1'b1;
        a         = 4'd1;
        b         = 4'd2;
        cin       = 1'b0;
        ndone     = 0;
        last_done = 0;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            if (done) begin
                check($sformatf("stream interval %0d", ndone), i - last_done, (ndone == 0) ? 5 : 6);
                check($sformatf("stream result %0d", ndone), {carry, sum}, 5'd3);
                last_done = i;
                ndone++;
            end
        end
        start = 1'b0;
        check("stream pulse count", ndone, 6);
        @(negedge clk);
        @(negedge clk);
        check("stream stops", busy, 0);

        // exhaustive sweep
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    exp5 = 5'(ia + ib + ic);
                    run_op(4'(ia), 4'(ib), 1'(ic), res, lat, nbusy);
                    if (lat != 5) check($sformatf("sweep %0d+%0d+%0d latency", ia, ib, ic), lat, 5);
                    check($sformatf("sweep %0d+%0d+%0d", ia, ib, ic), res, exp5);
                    @(negedge clk);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
